// File: rtl/j1e_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1e_mem_pkg
// Purpose  : Shared definitions for the J1e memory family.
//            - Read-during-write mode codes.
//            - Clear-sequencer state encodings.
//            - Lane-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package j1e_mem_pkg;

    // Same-port read-during-write behaviour
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Clear-sequencer states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Number of write-enable lanes in a word
    function automatic int LANES(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_lane.sv
`default_nettype none
// ============================================================================
// Module   : dpram_lane
// Purpose  : One LANE_W-wide slice of a single-clock true dual-port RAM.
//            - Write strobes i_we_a / i_we_b are pre-arbitrated by the parent.
//              The two strobes never target the same address in the same cycle.
//            - The read register loads only while the port's i_en_* is high.
//              Otherwise it holds its previous value.
// Ports    : clk, rst           clock, synchronous active-high reset
//            i_en_a/i_en_b      read-register update enables
//            i_we_a/i_we_b      lane write strobes
//            i_addr_a/i_addr_b  word addresses
//            i_di_a/i_di_b      lane write data
//            o_do_a/o_do_b      lane read data (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module dpram_lane
    import j1e_mem_pkg::*;
#(
    parameter int LANE_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en_a,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [LANE_W-1:0] i_di_a,
    output logic [LANE_W-1:0] o_do_a,
    input  logic              i_en_b,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [LANE_W-1:0] i_di_b,
    output logic [LANE_W-1:0] o_do_b
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [LANE_W-1:0] r_mem [0:c_DEPTH-1];
    logic [LANE_W-1:0] r_do_a;
    logic [LANE_W-1:0] r_do_b;

    // Storage array: no reset, contents are initialised by the clear sequencer
    always_ff @(posedge clk) begin
        if (i_we_b) r_mem[i_addr_b] <= i_di_b;
        if (i_we_a) r_mem[i_addr_a] <= i_di_a;
    end

    // Read registers. The array read sees the pre-edge contents, so any
    // cross-port write in the same cycle returns old data. Write-first mode
    // forwards only this port's own write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_do_a <= '0;
            r_do_b <= '0;
        end else begin
            if (i_en_a)
                r_do_a <= (RDW_MODE == RDW_WRITE_FIRST && i_we_a) ? i_di_a : r_mem[i_addr_a];
            if (i_en_b)
                r_do_b <= (RDW_MODE == RDW_WRITE_FIRST && i_we_b) ? i_di_b : r_mem[i_addr_b];
        end
    end

    assign o_do_a = r_do_a;
    assign o_do_b = r_do_b;

endmodule
`default_nettype wire

// File: rtl/dpram_lanes.sv
`default_nettype none
// ============================================================================
// Module   : dpram_lanes
// Purpose  : Parametrised single-clock true dual-port RAM for the J1e core.
//            Features:
//            - Per-lane write enables.
//            - Selectable same-port read-during-write mode.
//            - Write/write collision arbitration (port A wins per lane).
//            - Post-reset clear sequencer.
// Ports    : sys_clk_i, sys_rst_i  clock, synchronous active-high reset
//            rdy                   high once the array accepts accesses
//            ena/wea/addra/dia/doa port A (CPU data bus)
//            enb/web/addrb/dib/dob port B (loader / peripheral side)
//            coll                  pulse: overlapping-lane write on same address
// Config   : DPRAM_OUTREG_EN - extra doa/dob output register.
//            Read latency becomes 2 and coll is delayed to match.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_lanes
    import j1e_mem_pkg::*;
#(
    parameter int                 DATA_W       = 16,
    parameter int                 LANE_W       = 8,
    parameter int                 ADDR_W       = 13,
    parameter int                 RDW_MODE     = 0,
    parameter int                 CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VAL    = '0
) (
    input  logic                                sys_clk_i,
    input  logic                                sys_rst_i,
    output logic                                rdy,
    input  logic                                ena,
    input  logic [LANES(DATA_W, LANE_W)-1:0]    wea,
    input  logic [ADDR_W-1:0]                   addra,
    input  logic [DATA_W-1:0]                   dia,
    output logic [DATA_W-1:0]                   doa,
    input  logic                                enb,
    input  logic [LANES(DATA_W, LANE_W)-1:0]    web,
    input  logic [ADDR_W-1:0]                   addrb,
    input  logic [DATA_W-1:0]                   dib,
    output logic [DATA_W-1:0]                   dob,
    output logic                                coll
);

    localparam int c_LANES = LANES(DATA_W, LANE_W);

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic               r_coll;

    logic               w_acc;
    logic               w_clear;
    logic               w_same;
    logic               w_rd_a;
    logic               w_rd_b;
    logic [c_LANES-1:0] w_wr_a;
    logic [c_LANES-1:0] w_wr_b;
    logic [ADDR_W-1:0]  w_addr_a;
    logic [DATA_W-1:0]  w_di_a;
    logic [DATA_W-1:0]  w_doa_raw;
    logic [DATA_W-1:0]  w_dob_raw;

    // ------------------------------------------------------------------------
    // Clear sequencer: one word per cycle, DEPTH cycles, then IDLE until reset
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == {ADDR_W{1'b1}})
                r_state <= ST_IDLE;
        end
    end

    assign rdy = (r_state == ST_IDLE);

    // Gating with reset keeps the array untouched while state is undefined
    assign w_acc   = rdy & ~sys_rst_i;
    assign w_clear = (r_state == ST_CLEAR) & ~sys_rst_i;
    assign w_rd_a  = w_acc & ena;
    assign w_rd_b  = w_acc & enb;
    assign w_same  = (addra == addrb);

    // Port A carries the clear writes, so the sequencer needs no third port
    assign w_addr_a = w_clear ? r_clr_addr : addra;
    assign w_di_a   = w_clear ? CLEAR_VAL  : dia;
    assign w_wr_a   = w_clear ? {c_LANES{1'b1}} : (w_rd_a ? wea : '0);

    // Port B loses any lane that port A also writes at the same address
    assign w_wr_b = (w_rd_b ? web : '0) & ~(w_same ? w_wr_a : '0);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i)
            r_coll <= 1'b0;
        else
            r_coll <= w_rd_a & w_rd_b & w_same & (|(wea & web));
    end

    // ------------------------------------------------------------------------
    // Lane slices
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
        dpram_lane #(
            .LANE_W   (LANE_W),
            .ADDR_W   (ADDR_W),
            .RDW_MODE (RDW_MODE)
        ) u_lane (
            .clk      (sys_clk_i),
            .rst      (sys_rst_i),
            .i_en_a   (w_rd_a),
            .i_we_a   (w_wr_a[gi]),
            .i_addr_a (w_addr_a),
            .i_di_a   (w_di_a[gi*LANE_W +: LANE_W]),
            .o_do_a   (w_doa_raw[gi*LANE_W +: LANE_W]),
            .i_en_b   (w_rd_b),
            .i_we_b   (w_wr_b[gi]),
            .i_addr_b (addrb),
            .i_di_b   (dib[gi*LANE_W +: LANE_W]),
            .o_do_b   (w_dob_raw[gi*LANE_W +: LANE_W])
        );
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
`ifdef DPRAM_OUTREG_EN
    logic [DATA_W-1:0] r_doa_q;
    logic [DATA_W-1:0] r_dob_q;
    logic              r_coll_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_doa_q  <= '0;
            r_dob_q  <= '0;
            r_coll_q <= 1'b0;
        end else begin
            r_doa_q  <= w_doa_raw;
            r_dob_q  <= w_dob_raw;
            r_coll_q <= r_coll;
        end
    end

    assign doa  = r_doa_q;
    assign dob  = r_dob_q;
    assign coll = r_coll_q;
`else
    assign doa  = w_doa_raw;
    assign dob  = w_dob_raw;
    assign coll = r_coll;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_lanes
// Purpose  : Directed self-checking bench for dpram_lanes.
//            Configuration: 16-bit word, 8-bit lanes, 16 words, clear value A5A5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_lanes;

    localparam int               c_RDW  = 0;
    localparam logic [15:0]      c_CLR  = 16'hA5A5;
`ifdef DPRAM_OUTREG_EN
    localparam int               c_LAT  = 2;
`else
    localparam int               c_LAT  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [15:0] dia, dib;
    logic [15:0] doa, dob;
    logic        coll;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    dpram_lanes #(
        .DATA_W       (16),
        .LANE_W       (8),
        .ADDR_W       (4),
        .RDW_MODE     (c_RDW),
        .CLEAR_ON_RST (1),
        .CLEAR_VAL    (c_CLR)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .rdy       (rdy),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dia       (dia),
        .doa       (doa),
        .enb       (enb),
        .web       (web),
        .addrb     (addrb),
        .dib       (dib),
        .dob       (dob),
        .coll      (coll)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [3:0] a);
        ena = 1'b1; wea = 2'b00; addra = a;
        step();
        ena = 1'b0;
        repeat (c_LAT - 1) step();
    endtask

    task automatic rd_b(input logic [3:0] a);
        enb = 1'b1; web = 2'b00; addrb = a;
        step();
        enb = 1'b0;
        repeat (c_LAT - 1) step();
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        ena = 1'b1; wea = we; addra = a; dia = d;
        step();
        ena = 1'b0; wea = 2'b00;
    endtask

    // Count cycles until rdy rises, bounded so a stuck sequencer still ends
    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            step();
            cycles++;
            if (rdy) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0; wea = 2'b00; addra = '0; dia = '0;
        enb = 1'b0; web = 2'b00; addrb = '0; dib = '0;
        step();
        step();
        check("reset_doa",  doa,  16'h0000);
        check("reset_dob",  dob,  16'h0000);
        check("reset_coll", {15'd0, coll}, 16'h0000);
        check("reset_rdy",  {15'd0, rdy},  16'h0000);

        // Clear sequence: 16 cycles, every word becomes A5A5
        rst = 1'b0;
        wait_rdy(n);
        check("clear_cycles", n[15:0], 16'd16);
        for (int a = 0; a < 16; a++) begin
            rd_a(a[3:0]);
            check($sformatf("clear_word_%0d", a), doa, c_CLR);
        end

        // Full-word write then read back; doa holds with ena low
        wr_a(4'd3, 16'h1234, 2'b11);
        rd_a(4'd3);
        check("wr_rd_3", doa, 16'h1234);
        step();
        check("hold_doa", doa, 16'h1234);

        // Same-port read-during-write with partial lane write
        wr_a(4'd5, 16'hFFFF, 2'b11);
        ena = 1'b1; wea = 2'b01; addra = 4'd5; dia = 16'h00AB;
        step();
        ena = 1'b0; wea = 2'b00;
        repeat (c_LAT - 1) step();
        check("rdw_5", doa, (c_RDW == 1) ? 16'hFFAB : 16'hFFFF);
        rd_a(4'd5);
        check("lane_merge_5", doa, 16'hFFAB);

        // Write/write collision, overlapping lane 1: A wins, coll pulses
        ena = 1'b1; wea = 2'b11; addra = 4'd7; dia = 16'h1111;
        enb = 1'b1; web = 2'b10; addrb = 4'd7; dib = 16'h2222;
        step();
        ena = 1'b0; wea = 2'b00; enb = 1'b0; web = 2'b00;
        repeat (c_LAT - 1) step();
        check("coll_pulse", {15'd0, coll}, 16'h0001);
        step();
        check("coll_clear", {15'd0, coll}, 16'h0000);
        rd_a(4'd7);
        check("coll_word_7", doa, 16'h1111);

        // Disjoint lanes at the same address: both land, no collision
        ena = 1'b1; wea = 2'b01; addra = 4'd7; dia = 16'h1111;
        enb = 1'b1; web = 2'b10; addrb = 4'd7; dib = 16'h2222;
        step();
        ena = 1'b0; wea = 2'b00; enb = 1'b0; web = 2'b00;
        repeat (c_LAT - 1) step();
        check("nocoll", {15'd0, coll}, 16'h0000);
        rd_a(4'd7);
        check("merge_word_7", doa, 16'h2211);

        // Cross-port: B reads the word A writes in the same cycle
        ena = 1'b1; wea = 2'b11; addra = 4'd2; dia = 16'hBEEF;
        enb = 1'b1; web = 2'b00; addrb = 4'd2;
        step();
        ena = 1'b0; wea = 2'b00; enb = 1'b0;
        repeat (c_LAT - 1) step();
        check("xport_old_2", dob, c_CLR);
        rd_b(4'd2);
        check("xport_new_2", dob, 16'hBEEF);

        // Port B write, port A read
        enb = 1'b1; web = 2'b11; addrb = 4'd9; dib = 16'h5A5A;
        step();
        enb = 1'b0; web = 2'b00;
        rd_a(4'd9);
        check("b_wr_a_rd_9", doa, 16'h5A5A);

        // Reset in the middle of clearing restarts the full sequence
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (9) step();
        check("midclear_rdy", {15'd0, rdy}, 16'h0000);
        ena = 1'b1; wea = 2'b11; addra = 4'd3; dia = 16'hDEAD;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_rdy(n);
        ena = 1'b0; wea = 2'b00;
        check("reclear_cycles", n[15:0], 16'd16);
        check("reclear_doa_hold", doa, 16'h0000);
        rd_a(4'd3);
        check("reclear_word_3", doa, c_CLR);
        rd_a(4'd15);
        check("reclear_word_15", doa, c_CLR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
